// File: rtl/dec_cs_rr_arbiter_if.sv
// Requester-side bus of the chip-select round-robin arbiter: request vector in,
// decoder select/disable and one-hot grant mirror out.
interface dec_cs_rr_arbiter_if;
    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] a;
    logic             e;
    logic [N_REQ-1:0] gnt;
    logic             busy;

    modport master (output req, input a, e, gnt, busy);
    modport slave  (input req, output a, e, gnt, busy);
endinterface

// File: rtl/dec_cs_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low chip-select decoder among eight
// requesters, with a hold-time limit under contention and a break-before-make gap.
module dec_cs_rr_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic                clk,
    input logic                rst,
    dec_cs_rr_arbiter_if.slave bus
);
    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned GAP_W  = 4;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   a_q, a_d;
    logic               e_q, e_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   win_c;
    logic               release_c;

    // Circular scan from ptr; descending loop so the lowest offset from ptr wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_c = '0;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_q + IDX_W'(i);
            if (bus.req[idx]) begin
                win_c = idx;
            end
        end
    end

    assign release_c = !bus.req[a_q] ||
                       ((hold_cnt_q == HOLD_MAX) && (|(bus.req & ~gnt_q)));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        a_d        = a_q;
        e_d        = e_q;
        gnt_d      = gnt_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    a_d        = win_c;
                    e_d        = 1'b0;
                    gnt_d      = N_REQ'(1) << win_c;
                    hold_cnt_d = HOLD_W'(1);
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (release_c) begin
                    e_d       = 1'b1;
                    gnt_d     = '0;
                    ptr_d     = a_q + IDX_W'(1);
                    gap_cnt_d = GAP_W'(1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q < GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end else if (|bus.req) begin
                    a_d        = win_c;
                    e_d        = 1'b0;
                    gnt_d      = N_REQ'(1) << win_c;
                    hold_cnt_d = HOLD_W'(1);
                    state_d    = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            a_q        <= '0;
            e_q        <= 1'b1;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            a_q        <= a_d;
            e_q        <= e_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.e    = e_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/dec_cs_rr_arbiter.md
# dec_cs_rr_arbiter

Round-robin arbiter that shares one 3-to-8 active-low chip-select decoder among eight requesters. Its `a` and `e` outputs drive the decoder's select and disable inputs directly, so at most one active-low select line is ever low. It enforces a maximum hold time when other requesters are waiting. It also inserts a break-before-make gap, with all selects high, between consecutive grants.

## Interface
- `MAX_HOLD`, default 16: max grant cycles while another request is pending; range 1..255.
- `GAP_CYCLES`, default 1: cycles with `e`=1 between consecutive grants; range 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  8  request per requester, active-high, level-held until done.
- `a`  out  3  index of the granted requester, feeds the decoder select.
- `e`  out  1  decoder disable; 1 means all selects high, 0 means the select at `a` is low.
- `gnt`  out  8  one-hot grant mirror, active-high; all zero when `e`=1.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, GRANT, GAP.
- Internal state:
  - `ptr`, 3 bits: the highest-priority index.
  - `hold_cnt`, 8 bits.
  - `gap_cnt`, 4 bits.
- Arbitration picks the first set `req` bit scanning circularly from `ptr`: `ptr`, `ptr`+1, …, 7, 0, …, `ptr`-1.
- Reset state: IDLE, `a`=0, `e`=1, `gnt`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, `gap_cnt`=0.
- IDLE:
  - If `req`≠0, register the winner: `a`=winner, `e`=0, `gnt`=1<<winner, `hold_cnt`=1. Go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - Each cycle, `hold_cnt` increments and saturates at `MAX_HOLD`.
  - Release when either condition holds:
    - `req[a]`=0, or
    - `hold_cnt`=`MAX_HOLD` and (`req` & ~`gnt`)≠0.
  - On release: `e`=1, `gnt`=0, `ptr`=`a`+1 mod 8 (7 wraps to 0), `gap_cnt`=1. Go to GAP.
  - A sole requester with no competitor keeps the grant indefinitely; `hold_cnt` stays saturated.
  - If both release conditions are true in the same cycle, it is a single release with the same `ptr` update.
- GAP:
  - `e` stays 1 and `gnt` stays 0.
  - While `gap_cnt`<`GAP_CYCLES`, increment `gap_cnt`.
  - When `gap_cnt`=`GAP_CYCLES`:
    - If `req`≠0, arbitrate exactly as in IDLE and go to GRANT.
    - Otherwise go to IDLE.
- `a` holds the last granted index while `e`=1. It never changes while `e`=0.
- `req` is sampled only at arbitration edges (IDLE, or the last GAP cycle) and by the GRANT release check. Request changes during GAP before the last cycle have no effect.
- Reset asserted in any state, including mid-grant or mid-gap, forces all reset values at the next edge. `e`=1 from the cycle after that edge.

## Timing
- Request to grant: `req` high at edge k in IDLE gives `e`=0 and a valid `a`/`gnt` from cycle k+1. Latency is 1 cycle.
- Release: `req[a]` low at edge r gives `e`=1 from cycle r+1. Latency is 1 cycle.
- Back-to-back grants have exactly `GAP_CYCLES` cycles with `e`=1 between them. There is never a cycle where two selects are low or where `a` changes with `e`=0.
- Timeout: with competitors pending throughout, a grant lasts exactly `MAX_HOLD` cycles of `e`=0.
- Saturated sole holder: if a competitor appears at edge c while `hold_cnt`=`MAX_HOLD`, release occurs at edge c and `e`=1 from cycle c+1.
- `busy` is registered alongside the state. It is 1 in GRANT and GAP.
- The outputs `a`, `e`, `gnt` and `busy` are registered, with no combinational path from `req`.

## Test plan
- Reset values: hold `rst`=1 with `req`=8'hFF, then release `rst` → during reset `a`=0, `e`=1, `gnt`=0, `busy`=0. One cycle after `rst` falls, `a`=0, `e`=0, `gnt`=8'h01.
- Single requester: `req`=8'h04 held for 5 cycles, then 0 → `a`=2, `e`=0, `gnt`=8'h04 one cycle after assertion. `e`=1 one cycle after the drop, then IDLE after `GAP_CYCLES`.
- Full round robin: `req`=8'hFF constant, `MAX_HOLD`=4, `GAP_CYCLES`=1 → grants 0,1,…,7,0 in order, each 4 cycles with `e`=0, separated by 1 cycle with `e`=1. `gnt` is always one-hot or zero.
- Wrap-around: drive `ptr` to 6 (grant and release requester 5), then `req`=8'h41 → grant 6 first, then 0 after its release.
- Timeout vs sole holder: `MAX_HOLD`=4.
  - `req[3]` alone for 10 cycles → grant 3 held all 10 cycles.
  - Then assert `req[5]` → grant 3 released the next edge, gap, then grant 5.
- Reset mid-grant, and simultaneous drop plus timeout:
  - Assert `rst` during a GRANT → `e`=1, `gnt`=0 and `ptr`=0 at the next edge.
  - Drop `req[a]` in the same cycle its timeout fires → a single release and a single `ptr` increment.
